// File: rtl/branch_resolve_if.sv
// Decode/fetch side bus of the execute-stage branch resolver.
//   D-stage inputs : stallE, validD, opD, funct3D, pcD, next_pcD, immD, rs1D, rs2D
//   Fetch outputs  : branch_sig, branch_pc, branch_plus4, success, failure
//   Decode output  : flushD
// master = pipeline/fetch side (drives D inputs), slave = resolver.
interface branch_resolve_if;
    logic        stallE;
    logic        validD;
    logic [6:0]  opD;
    logic [2:0]  funct3D;
    logic [31:0] pcD;
    logic [31:0] next_pcD;
    logic [31:0] immD;
    logic [31:0] rs1D;
    logic [31:0] rs2D;
    logic        branch_sig;
    logic [31:0] branch_pc;
    logic [31:0] branch_plus4;
    logic        success;
    logic        failure;
    logic        flushD;

    modport master (
        output stallE, validD, opD, funct3D, pcD, next_pcD, immD, rs1D, rs2D,
        input  branch_sig, branch_pc, branch_plus4, success, failure, flushD
    );

    modport slave (
        input  stallE, validD, opD, funct3D, pcD, next_pcD, immD, rs1D, rs2D,
        output branch_sig, branch_pc, branch_plus4, success, failure, flushD
    );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage control-transfer resolver.
// Latches the decode instruction into an execute register, resolves
// branch/jal/jalr, compares the actual next PC with what fetch followed and
// reports the outcome to fetch exactly once per control instruction.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   bus        : branch_resolve_if.slave (D inputs, fetch report, flushD)
//   br_count   : resolved control transfers, saturating
//   miss_count : mispredicts, saturating
module branch_resolve #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolve_if.slave  bus,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [1:0] {EMPTY, PENDING, DONE} state_t;

    state_t      state_q, state_d;
    logic        validE_q;
    logic [6:0]  opE_q;
    logic [2:0]  funct3E_q;
    logic [31:0] pcE_q, next_pcE_q, immE_q, rs1E_q, rs2E_q;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

    logic        is_br, is_jal, is_jalr, cond, taken, mis, report, load_ctl;
    logic [31:0] target, plus4, actual;

    // Execute register; a flushed decode slot enters as a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validE_q   <= 1'b0;
            opE_q      <= '0;
            funct3E_q  <= '0;
            pcE_q      <= '0;
            next_pcE_q <= '0;
            immE_q     <= '0;
            rs1E_q     <= '0;
            rs2E_q     <= '0;
        end else if (!bus.stallE) begin
            validE_q   <= bus.validD & ~bus.flushD;
            opE_q      <= bus.opD;
            funct3E_q  <= bus.funct3D;
            pcE_q      <= bus.pcD;
            next_pcE_q <= bus.next_pcD;
            immE_q     <= bus.immD;
            rs1E_q     <= bus.rs1D;
            rs2E_q     <= bus.rs2D;
        end
    end

    always_comb begin
        is_br   = validE_q && (opE_q == OP_BR);
        is_jal  = validE_q && (opE_q == OP_JAL);
        is_jalr = validE_q && (opE_q == OP_JALR);

        case (funct3E_q)
            3'b000:  cond = (rs1E_q == rs2E_q);
            3'b001:  cond = (rs1E_q != rs2E_q);
            3'b100:  cond = ($signed(rs1E_q) <  $signed(rs2E_q));
            3'b101:  cond = ($signed(rs1E_q) >= $signed(rs2E_q));
            3'b110:  cond = (rs1E_q <  rs2E_q);
            3'b111:  cond = (rs1E_q >= rs2E_q);
            default: cond = 1'b0;
        endcase

        target = is_jalr ? ((rs1E_q + immE_q) & ~32'h1) : (pcE_q + immE_q);
        plus4  = pcE_q + 32'd4;
        taken  = is_jal | is_jalr | (is_br & cond);
        actual = taken ? target : plus4;
        mis    = (actual != next_pcE_q);
        report = (state_q == PENDING);

        // Quiet outputs are forced to zero rather than left floating.
        bus.success      = report & ~mis;
        bus.failure      = report &  mis;
        bus.flushD       = report &  mis;
        bus.branch_sig   = report &  taken;
        bus.branch_pc    = report ? target : 32'h0;
        bus.branch_plus4 = report ? plus4  : 32'h0;
    end

    // flushD comes from registered state only, so this does not loop back.
    assign load_ctl = bus.validD & ~bus.flushD &
                      ((bus.opD == OP_BR) | (bus.opD == OP_JAL) | (bus.opD == OP_JALR));

    // PENDING lasts one cycle; a stall parks the already-reported
    // instruction in DONE so it cannot report twice.
    always_comb begin
        state_d = state_q;
        if (!bus.stallE)
            state_d = load_ctl ? PENDING : EMPTY;
        else if (state_q == PENDING)
            state_d = DONE;
    end

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (report && (br_cnt_q != {CNT_W{1'b1}}))
            br_cnt_d = br_cnt_q + 1'b1;
        if (report && mis && (miss_cnt_q != {CNT_W{1'b1}}))
            miss_cnt_d = miss_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign br_count   = br_cnt_q;
    assign miss_count = miss_cnt_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: a 32-bit-counter instance driven with directed
// vectors (reports checked by a scoreboard monitor) and a 4-bit-counter
// instance used for counter saturation.
module tb_branch_resolve;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] ALU  = 7'b0110011;

    typedef struct {
        logic        sig;
        logic [31:0] pc;
        logic [31:0] p4;
        logic        suc;
        logic        fail;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] brc, msc;
    logic [3:0]  brc4, msc4;
    int chks = 0;
    int errs = 0;
    exp_t sbq[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    branch_resolve_if ifa();
    branch_resolve_if ifb();

    branch_resolve #(.CNT_W(32)) dut (
        .clk(clk), .reset(rst_n), .bus(ifa), .br_count(brc), .miss_count(msc));
    branch_resolve #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(rst_n), .bus(ifb), .br_count(brc4), .miss_count(msc4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Present one D instruction for one cycle; returns #1 after the load edge.
    task automatic drv(input bit b, input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] imm,
                       input logic [31:0] r1, input logic [31:0] r2);
        if (!b) begin
            ifa.validD = v; ifa.opD = op; ifa.funct3D = f3; ifa.pcD = pc;
            ifa.next_pcD = npc; ifa.immD = imm; ifa.rs1D = r1; ifa.rs2D = r2;
        end else begin
            ifb.validD = v; ifb.opD = op; ifb.funct3D = f3; ifb.pcD = pc;
            ifb.next_pcD = npc; ifb.immD = imm; ifb.rs1D = r1; ifb.rs2D = r2;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit b);
        drv(b, 1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic push(input logic sig, input logic [31:0] pc, input logic [31:0] p4,
                        input logic suc, input logic fail);
        exp_t e;
        e.sig = sig; e.pc = pc; e.p4 = p4; e.suc = suc; e.fail = fail;
        sbq.push_back(e);
    endtask

    // Monitor: each report pops one expected entry; quiet cycles must be all zero.
    always @(negedge clk) begin
        if (ifa.success || ifa.failure) begin
            if (sbq.size() == 0) begin
                chks++; errs++;
                $display("FAIL unexpected_report: success=%0b failure=%0b pc=0x%08h, none expected",
                         ifa.success, ifa.failure, ifa.branch_pc);
            end else begin
                mon_e = sbq.pop_front();
                chk("rep_success", {31'b0, ifa.success}, {31'b0, mon_e.suc});
                chk("rep_failure", {31'b0, ifa.failure}, {31'b0, mon_e.fail});
                chk("rep_flushD", {31'b0, ifa.flushD}, {31'b0, mon_e.fail});
                chk("rep_branch_sig", {31'b0, ifa.branch_sig}, {31'b0, mon_e.sig});
                chk("rep_branch_pc", ifa.branch_pc, mon_e.pc);
                chk("rep_branch_plus4", ifa.branch_plus4, mon_e.p4);
            end
        end else begin
            chk("quiet_outputs", {28'b0, ifa.branch_sig, ifa.flushD,
                                  |ifa.branch_pc, |ifa.branch_plus4}, 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ifa.stallE = 1'b0; ifb.stallE = 1'b0;
        ifa.validD = 1'b0; ifa.opD = '0; ifa.funct3D = '0; ifa.pcD = '0;
        ifa.next_pcD = '0; ifa.immD = '0; ifa.rs1D = '0; ifa.rs2D = '0;
        ifb.validD = 1'b0; ifb.opD = '0; ifb.funct3D = '0; ifb.pcD = '0;
        ifb.next_pcD = '0; ifb.immD = '0; ifb.rs1D = '0; ifb.rs2D = '0;
        #12;
        chk("reset_success", {31'b0, ifa.success}, 32'h0);
        chk("reset_failure", {31'b0, ifa.failure}, 32'h0);
        chk("reset_br_count", brc, 32'h0);
        chk("reset_miss_count", msc, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        idle(0);

        // beq taken, predicted correctly
        push(1'b1, 32'h8010, 32'h8004, 1'b1, 1'b0);
        drv(0, 1, BR, 3'b000, 32'h8000, 32'h8010, 32'h10, 32'd5, 32'd5);
        // bne not taken, fetch went to target -> mispredict
        push(1'b0, 32'h8040, 32'h8024, 1'b0, 1'b1);
        drv(0, 1, BR, 3'b001, 32'h8020, 32'h8040, 32'h20, 32'd7, 32'd7);
        chk("beq_br_count", brc, 32'd1);
        chk("beq_miss_count", msc, 32'd0);
        // wrong-path control instruction, must be squashed (no report)
        drv(0, 1, BR, 3'b000, 32'h8040, 32'h8000, 32'h40, 32'd1, 32'd1);
        chk("bne_br_count", brc, 32'd2);
        chk("bne_miss_count", msc, 32'd1);

        // jalr target bit 0 cleared, fetch followed pc+4
        push(1'b1, 32'h9004, 32'h8004, 1'b0, 1'b1);
        drv(0, 1, JALR, 3'b000, 32'h8000, 32'h8004, 32'h4, 32'h9001, 32'h0);
        drv(0, 1, ALU, 3'b000, 32'h8004, 32'h8008, 32'h0, 32'h0, 32'h0);
        chk("jalr_br_count", brc, 32'd3);
        chk("jalr_miss_count", msc, 32'd2);

        // blt signed taken, stalled 3 cycles -> one report
        push(1'b1, 32'h8140, 32'h8104, 1'b1, 1'b0);
        drv(0, 1, BR, 3'b100, 32'h8100, 32'h8140, 32'h40, 32'hFFFFFFFF, 32'd1);
        ifa.stallE = 1'b1; ifa.validD = 1'b0;
        repeat (3) @(posedge clk);
        #1; ifa.stallE = 1'b0;
        idle(0);
        chk("blt_stall_br_count", brc, 32'd4);
        // bltu not taken, same operands, stalled 3 cycles
        push(1'b0, 32'h8240, 32'h8204, 1'b1, 1'b0);
        drv(0, 1, BR, 3'b110, 32'h8200, 32'h8204, 32'h40, 32'hFFFFFFFF, 32'd1);
        ifa.stallE = 1'b1; ifa.validD = 1'b0;
        repeat (3) @(posedge clk);
        #1; ifa.stallE = 1'b0;
        idle(0);
        chk("bltu_stall_br_count", brc, 32'd5);
        chk("bltu_stall_miss_count", msc, 32'd2);

        // back-to-back correctly predicted transfers
        push(1'b1, 32'h8400, 32'h8304, 1'b1, 1'b0);
        drv(0, 1, JAL, 3'b000, 32'h8300, 32'h8400, 32'h100, 32'h0, 32'h0);
        push(1'b1, 32'h8408, 32'h8404, 1'b1, 1'b0);
        drv(0, 1, BR, 3'b101, 32'h8400, 32'h8408, 32'h8, 32'd1, 32'hFFFFFFFF);
        push(1'b0, 32'h8410, 32'h840C, 1'b1, 1'b0);
        drv(0, 1, BR, 3'b111, 32'h8408, 32'h840C, 32'h8, 32'd1, 32'hFFFFFFFF);
        push(1'b0, 32'h8414, 32'h8410, 1'b1, 1'b0);
        drv(0, 1, BR, 3'b010, 32'h840C, 32'h8410, 32'h8, 32'h0, 32'h0);
        drv(0, 1, ALU, 3'b000, 32'h8410, 32'h8600, 32'h0, 32'h0, 32'h0);
        chk("b2b_br_count", brc, 32'd9);
        idle(0);
        chk("b2b_miss_count", msc, 32'd2);

        // reset while a mispredicting jal sits in E
        drv(0, 1, JAL, 3'b000, 32'h8500, 32'h8504, 32'h20, 32'h0, 32'h0);
        rst_n = 1'b0;
        ifa.validD = 1'b0;
        #1;
        chk("rst_failure", {31'b0, ifa.failure}, 32'h0);
        chk("rst_branch_pc", ifa.branch_pc, 32'h0);
        chk("rst_br_count", brc, 32'h0);
        chk("rst_miss_count", msc, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_failure", {31'b0, ifa.failure}, 32'h0);
        chk("post_rst_plus4", ifa.branch_plus4, 32'h0);
        chk("post_rst_br_count", brc, 32'h0);

        // 4-bit counters saturate after 20 mispredicts + squash bubbles
        for (int i = 0; i < 20; i++) begin
            drv(1, 1, BR, 3'b001, 32'h100 + 32'(16 * i), 32'h108 + 32'(16 * i), 32'h8, 32'd7, 32'd7);
            drv(1, 1, BR, 3'b001, 32'h108 + 32'(16 * i), 32'h200, 32'h8, 32'd7, 32'd7);
            if (i == 3) begin
                chk("cnt4_miss_at4", {28'b0, msc4}, 32'd4);
                chk("cnt4_br_at4", {28'b0, brc4}, 32'd4);
            end
            if (i == 14) chk("cnt4_miss_at15", {28'b0, msc4}, 32'd15);
        end
        idle(1);
        chk("cnt4_miss_sat", {28'b0, msc4}, 32'd15);
        chk("cnt4_br_sat", {28'b0, brc4}, 32'd15);

        @(posedge clk); #1;
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", chks, errs);
        $finish;
    end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage control-transfer resolver: the consumer end of the fetch redirect/prediction interface. It latches the decode-stage instruction into an execute register and evaluates branch, jal and jalr outcomes. It compares the actual next PC with the address fetch followed, then drives fetch's `branch_sig`/`branch_pc`/`branch_plus4`/`success`/`failure` inputs. On a mispredict it squashes the single wrong-path instruction and keeps prediction statistics.

## Interface
- `CNT_W`, default 32: width of the statistics counters.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `stallE` in 1: hold the execute register and FSM.
- `validD` in 1: decode slot holds a real instruction.
- `opD` in 7: opcode, ir[6:0].
- `funct3D` in 3: ir[14:12].
- `pcD` in 32: PC of the decode instruction.
- `next_pcD` in 32: address fetch issued after this instruction.
- `immD` in 32: sign-extended B/J/I immediate.
- `rs1D` in 32: rs1 value, already forwarded.
- `rs2D` in 32: rs2 value, already forwarded.
- `branch_sig` out 1: resolved control transfer is taken.
- `branch_pc` out 32: resolved taken target.
- `branch_plus4` out 32: PC+4 of the resolved instruction.
- `success` out 1: one-cycle pulse; prediction correct.
- `failure` out 1: one-cycle pulse; mispredict, fetch must redirect.
- `flushD` out 1: kill the instruction currently in decode.
- `br_count` out CNT_W: resolved control transfers, saturating.
- `miss_count` out CNT_W: mispredicts, saturating.

## Operation
- Execute register fields: validE, opE, funct3E, pcE, next_pcE, immE, rs1E, rs2E.
  - On each rising edge with `!stallE`, the register loads the D inputs.
  - validE loads `validD & !flushD`.
- Control instruction classes, when validE:
  - BR: opE = 1100011.
  - JAL: opE = 1101111.
  - JALR: opE = 1100111.
  - All other opcodes pass through with no effect.
- BR condition by funct3:
  - 000 eq; 001 ne.
  - 100 signed lt; 101 signed ge.
  - 110 unsigned lt; 111 unsigned ge.
  - 010 and 011 are never taken.
- Targets:
  - BR and JAL: pcE+immE.
  - JALR: (rs1E+immE) with bit 0 cleared.
  - All arithmetic is mod 2^32.
- Resolution:
  - taken = JAL | JALR | (BR & cond).
  - actual = taken ? target : pcE+4.
  - mis = (actual != next_pcE).
- FSM states: EMPTY, PENDING, DONE.
  - EMPTY → PENDING when the register loads a valid control instruction.
  - PENDING: report combinationally this cycle. Go to DONE if `stallE`; otherwise re-evaluate on the newly loaded content.
  - DONE: outputs silent. Leave DONE when `!stallE`, taking the next state from the new content.
  - A non-control or invalid load gives EMPTY.
- Reporting, only in PENDING:
  - `success` = !mis.
  - `failure` = mis.
  - `branch_sig` = taken.
  - `branch_pc` = target.
  - `branch_plus4` = pcE+4.
  - `flushD` = mis.
  - Each control instruction reports exactly once, however long it is stalled.
- Fetch selection on `failure`: `branch_pc` if `branch_sig`, else `branch_plus4`.
- Counters update at the reporting edge:
  - `br_count`+1 on each report.
  - `miss_count`+1 on `failure`.
  - Both hold at all-ones.

## Timing
- Reset values:
  - validE=0, state EMPTY.
  - All outputs 0, including `branch_pc`/`branch_plus4`.
  - Counters 0.
- Latency: an instruction on D at edge N is in E during cycle N..N+1. Its report is valid combinationally in that cycle; fetch samples it at edge N+1.
- Mispredict at edge N+1:
  - Fetch redirects.
  - The wrong-path D instruction enters E with validE=0.
  - The correct target reaches D in the following cycle.
- Squash cost: exactly one bubble per failure. Back-to-back control instructions are resolved every cycle when there is no failure.
- Stall while PENDING:
  - The report pulses in the first stalled cycle only.
  - `flushD` is also asserted only in that cycle. The stall owner must not let D advance while a stall and a flush coincide.
- Reset deassertion mid-instruction: the in-flight instruction is discarded. There is no report; E is empty on the first post-reset edge.
- The non-reporting value of `branch_pc`/`branch_plus4` is don't-care for fetch, but is driven as 0.

## Test plan
- beq, rs1=rs2=5, pc=0x8000, imm=0x10, next_pc=0x8010 → `success`=1, `branch_sig`=1, `branch_pc`=0x8010, `failure`=0, `br_count`=1.
- bne, rs1=rs2=7, pc=0x8020, next_pc=0x8040 → `failure`=1, `branch_sig`=0, `branch_plus4`=0x8024, `flushD`=1. The next E load has validE=0; `miss_count`=1.
- jalr, rs1=0x9001, imm=0x4, next_pc=0x8004 → `branch_pc`=0x9004 (bit 0 cleared), `failure`=1, `branch_sig`=1.
- blt, rs1=0xFFFFFFFF, rs2=1 with `stallE` held 3 cycles → exactly one `success` pulse; `br_count` increments once. Repeat with bltu, which is not taken.
- `reset` low while a mispredicting jal sits in E → no `failure` pulse; all outputs 0 and counters 0 on release.
- `CNT_W`=4, 20 consecutive mispredicts (each followed by its squash bubble) → `miss_count` and `br_count` stop at 15.
